// File: rtl/pc_fetch_unit.sv
// Program counter / flash address generator feeding the control unit.
// Optional hardware return stack is built only when PC_STACK_EN is defined.
module pc_fetch_unit #(
    parameter logic [11:0] RESET_VECTOR = 12'h000,
    parameter int          FLASH_DEPTH  = 4096,
    parameter int          STACK_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [11:0] pc_next,
    input  logic        halt,
    input  logic        call_push,
    input  logic        ret_pop,
    output logic [11:0] flash_addr,
    output logic        pc_wrap,
    output logic        misalign,
    output logic        stack_err,
    output logic [4:0]  stack_level
);
    localparam logic [11:0] PC_LAST = 12'(FLASH_DEPTH - 1);

    logic [11:0] pc_q, pc_d;
    logic        pc_wrap_q, pc_wrap_d;
    logic        misalign_q, misalign_d;

`ifdef PC_STACK_EN
    localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [STACK_DEPTH-1:0][11:0] stack_q, stack_d;
    logic [4:0]                   level_q, level_d;
    logic                         stack_err_q, stack_err_d;
    logic [SW-1:0]                push_idx, top_idx;

    assign push_idx = SW'(level_q);
    assign top_idx  = SW'(level_q - 5'd1);
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = call_push ^ ret_pop;
`endif

    always_comb begin
        pc_d       = pc_q;
        pc_wrap_d  = 1'b0;
        misalign_d = misalign_q;
`ifdef PC_STACK_EN
        stack_d     = stack_q;
        level_d     = level_q;
        stack_err_d = stack_err_q;
`endif
        if (!halt) begin
`ifdef PC_STACK_EN
            // Return beats call; an empty-stack return leaves the PC where it is.
            if (ret_pop) begin
                if (level_q == 5'd0) begin
                    stack_err_d = 1'b1;
                end else begin
                    pc_d    = stack_q[top_idx];
                    level_d = level_q - 5'd1;
                end
            end else if (call_push) begin
                pc_d = pc_next;
                if (pc_next[0]) misalign_d = 1'b1;
                if (level_q == 5'(STACK_DEPTH)) begin
                    stack_err_d = 1'b1;
                end else begin
                    stack_d[push_idx] = pc_q;
                    level_d           = level_q + 5'd1;
                end
            end else
`endif
            if (pc_load) begin
                pc_d = pc_next;
                if (pc_next[0]) misalign_d = 1'b1;
            end else if (pc_inc) begin
                if (pc_q == PC_LAST) begin
                    pc_d      = 12'h000;
                    pc_wrap_d = 1'b1;
                end else begin
                    pc_d = pc_q + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q       <= RESET_VECTOR;
            pc_wrap_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_wrap_q  <= pc_wrap_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_STACK_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stack_q     <= '0;
            level_q     <= 5'd0;
            stack_err_q <= 1'b0;
        end else begin
            stack_q     <= stack_d;
            level_q     <= level_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign stack_err   = stack_err_q;
    assign stack_level = level_q;
`else
    assign stack_err   = 1'b0;
    assign stack_level = 5'd0;
`endif

    assign flash_addr = pc_q;
    assign pc_wrap    = pc_wrap_q;
    assign misalign   = misalign_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes model predictions,
// a monitor pops and compares them one cycle after each sampled edge.
module tb_pc_fetch_unit;
    localparam logic [11:0] RV = 12'h000;
    localparam int          FD = 256;
    localparam int          SD = 2;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        pc_inc = 1'b0, pc_load = 1'b0, halt = 1'b0;
    logic        call_push = 1'b0, ret_pop = 1'b0;
    logic [11:0] pc_next = 12'h000;
    logic [11:0] flash_addr;
    logic        pc_wrap, misalign, stack_err;
    logic [4:0]  stack_level;

    pc_fetch_unit #(.RESET_VECTOR(RV), .FLASH_DEPTH(FD), .STACK_DEPTH(SD)) dut (
        .clk(clk), .arst_n(arst_n), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_next(pc_next), .halt(halt), .call_push(call_push), .ret_pop(ret_pop),
        .flash_addr(flash_addr), .pc_wrap(pc_wrap), .misalign(misalign),
        .stack_err(stack_err), .stack_level(stack_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        wrap, mis, err;
        logic [4:0]  lvl;
    } exp_t;

    exp_t expq[$];
    int   checks = 0, failures = 0;

    // Behavioural model
    int unsigned m_pc = RV;
    bit          m_wrap = 0, m_mis = 0, m_err = 0;
    logic [11:0] m_stk[$];

    task automatic model_reset();
        m_pc = RV; m_wrap = 0; m_mis = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic check_now(input string name);
        logic [4:0] lvl;
        lvl = 5'(m_stk.size());
        checks++;
        if (flash_addr !== 12'(m_pc) || pc_wrap !== m_wrap || misalign !== m_mis ||
            stack_err !== m_err || stack_level !== lvl) begin
            failures++;
            $display("FAIL %s: got addr=%h wrap=%b mis=%b err=%b lvl=%0d, want addr=%h wrap=%b mis=%b err=%b lvl=%0d",
                     name, flash_addr, pc_wrap, misalign, stack_err, stack_level,
                     12'(m_pc), m_wrap, m_mis, m_err, lvl);
        end
    endtask

    // Drive one cycle of inputs (called just after a negedge) and predict the result.
    task automatic step(input bit inc, input bit ld, input logic [11:0] nx,
                        input bit hl, input bit cl, input bit rt);
        exp_t e;
        pc_inc = inc; pc_load = ld; pc_next = nx; halt = hl; call_push = cl; ret_pop = rt;
        m_wrap = 0;
        if (!hl) begin
`ifdef PC_STACK_EN
            if (rt) begin
                if (m_stk.size() == 0) m_err = 1;
                else m_pc = m_stk.pop_back();
            end else if (cl) begin
                if (m_stk.size() == SD) m_err = 1;
                else m_stk.push_back(12'(m_pc));
                m_pc = nx;
                if (nx[0]) m_mis = 1;
            end else
`endif
            if (ld) begin
                m_pc = nx;
                if (nx[0]) m_mis = 1;
            end else if (inc) begin
                if (m_pc == FD - 1) begin
                    m_pc = 0; m_wrap = 1;
                end else begin
                    m_pc = (m_pc + 1) % 4096;
                end
            end
        end
        e.addr = 12'(m_pc); e.wrap = m_wrap; e.mis = m_mis; e.err = m_err;
        e.lvl = 5'(m_stk.size());
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(); step(0, 0, 12'h000, 0, 0, 0); endtask
    task automatic load(input logic [11:0] a); step(0, 1, a, 0, 0, 0); endtask

    // Monitor: compare one prediction per edge, away from the edge.
    always @(posedge clk) begin
        #1;
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            checks++;
            if (flash_addr !== e.addr || pc_wrap !== e.wrap || misalign !== e.mis ||
                stack_err !== e.err || stack_level !== e.lvl) begin
                failures++;
                $display("FAIL cycle_cmp @%0t: got addr=%h wrap=%b mis=%b err=%b lvl=%0d, want addr=%h wrap=%b mis=%b err=%b lvl=%0d",
                         $time, flash_addr, pc_wrap, misalign, stack_err, stack_level,
                         e.addr, e.wrap, e.mis, e.err, e.lvl);
            end
        end
    end

    initial begin
        #3;
        check_now("reset_state");
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // increment from reset vector
        repeat (3) step(1, 0, 12'h000, 0, 0, 0);
        idle();

        // asynchronous reset mid-run
        load(12'h123);
        @(posedge clk); #3;
        arst_n = 1'b0;
        model_reset();
        #1 check_now("async_reset");
        @(negedge clk);
        arst_n = 1'b1;

        // load beats inc; odd target sets sticky misalign
        load(12'h010);
        step(1, 1, 12'h2A4, 0, 0, 0);
        step(1, 1, 12'h2A5, 0, 0, 0);
        load(12'h040);
        idle();

        // wrap at FLASH_DEPTH-1, pulse lasts one cycle
        load(12'h0FE);
        step(1, 0, 12'h000, 0, 0, 0);
        step(1, 0, 12'h000, 0, 0, 0);
        step(1, 0, 12'h000, 0, 0, 0);
        idle();

        // out-of-range load kept as-is, then 12-bit increment
        load(12'hFFE);
        repeat (2) step(1, 0, 12'h000, 0, 0, 0);

        // halt freezes everything
        load(12'h050);
        step(1, 1, 12'h300, 1, 1, 1);
        step(1, 0, 12'h000, 0, 0, 0);

        // stack behaviour (call/ret ignored when the stack is compiled out)
        load(12'h020);
        step(0, 0, 12'h100, 0, 1, 0);
        step(0, 0, 12'h000, 0, 0, 1);
        step(0, 0, 12'h000, 0, 0, 1);
        step(0, 0, 12'h200, 0, 1, 0);
        step(0, 0, 12'h300, 0, 1, 0);
        step(0, 0, 12'h400, 0, 1, 0);
        step(0, 1, 12'h500, 0, 1, 1);
        step(1, 0, 12'h000, 0, 0, 1);

        // reset to clear sticky flags before random traffic
        @(posedge clk); #3;
        arst_n = 1'b0;
        model_reset();
        #1 check_now("reset_before_random");
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            bit inc, ld, hl, cl, rt;
            logic [11:0] nx;
            inc = ($urandom_range(0, 9) < 6);
            ld  = ($urandom_range(0, 9) == 0);
            hl  = ($urandom_range(0, 15) == 0);
            cl  = ($urandom_range(0, 11) == 0);
            rt  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: nx = 12'(FD - 2 + $urandom_range(0, 1));
                1: nx = 12'($urandom_range(0, 4095));
                default: nx = 12'($urandom_range(0, FD / 2 - 1) * 2);
            endcase
            step(inc, ld, nx, hl, cl, rt);
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d predictions left, want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
